// File: rtl/code_entry_checker.sv
// -----------------------------------------------------------------------------
// code_entry_checker
//
// Front end of the six-digit electronic lock. It collects BCD key digits,
// compares the entry against the stored code when enter is pressed, counts
// consecutive failed attempts, opens the door for a fixed time, and raises
// the alarm after MAX_TRIES failures. The alarm is held until the LED flasher
// reports end of flashing with a fresh 0->1 edge on alarm_done.
//
// Optional feature macro: CODE_CHANGE_EN
//   When defined, the code lives in a register that resets to CODE. While the
//   door is open, six digits followed by enter replace the code, and
//   code_changed pulses for one cycle.
//
// Parameters:
//   CODE         six BCD digits; the most significant nibble is keyed first
//   MAX_TRIES    consecutive failures that raise the alarm (1..7)
//   OPEN_CYCLES  clk cycles that unlock stays high (>= 1)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   key_valid     one-cycle strobe, key_digit is valid
//   key_digit     BCD digit 0..9; 10..15 are dropped
//   key_enter     one-cycle strobe, submit the entry
//   key_clear     one-cycle strobe, discard the entry
//   key_lock      one-cycle strobe, relock early while open
//   alarm_done    end-of-flash flag from the flasher (may stay high)
//   unlock        door open
//   alarm         drives the flasher switch input
//   digit_count   digits held, 0..6
//   err_count     consecutive failures, saturates at MAX_TRIES
//   entry         entered digits, right-justified
//   code_changed  (CODE_CHANGE_EN only) one-cycle pulse after a code change
// -----------------------------------------------------------------------------
module code_entry_checker #(
    parameter logic [23:0] CODE        = 24'h123456,
    parameter int          MAX_TRIES   = 3,
    parameter logic [15:0] OPEN_CYCLES = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_enter,
    input  logic        key_clear,
    input  logic        key_lock,
    input  logic        alarm_done,
    output logic        unlock,
    output logic        alarm,
    output logic [2:0]  digit_count,
    output logic [2:0]  err_count,
    output logic [23:0] entry
`ifdef CODE_CHANGE_EN
    ,
    output logic        code_changed
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OPEN  = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [2:0]  MAX_ERR   = 3'(MAX_TRIES);
    localparam logic [15:0] OPEN_LOAD = OPEN_CYCLES - 16'd1;

    state_t      state;
    state_t      state_next;
    logic [15:0] timer;
    logic        done_q;
    logic [23:0] code_ref;
    logic        match;
    logic [2:0]  err_inc;
    logic        done_rise;
    logic        open_exit;
    logic        keys_live;
    logic        digit_ok;
    logic        code_load;

`ifdef CODE_CHANGE_EN
    logic [23:0] code_reg;
    assign code_ref  = code_reg;
    // Keys follow the IDLE rules while open, except in the cycle the door relocks.
    assign keys_live = (state == IDLE) || ((state == OPEN) && !open_exit);
    assign code_load = (state == OPEN) && !open_exit && !key_clear && key_enter
                       && (digit_count == 3'd6);
`else
    assign code_ref  = CODE;
    assign keys_live = (state == IDLE);
    assign code_load = 1'b0;
`endif

    assign match     = (digit_count == 3'd6) && (entry == code_ref);
    assign err_inc   = (err_count >= MAX_ERR) ? MAX_ERR : err_count + 3'd1;
    assign done_rise = alarm_done && !done_q;
    assign open_exit = (state == OPEN) && ((timer == 16'd0) || key_lock);
    assign digit_ok  = key_valid && (key_digit <= 4'd9) && (digit_count < 3'd6);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default assignment ahead of the case keeps every path
        // assigned, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:  if (!key_clear && key_enter) state_next = CHECK;
            CHECK: begin
                if (match)                   state_next = OPEN;
                else if (err_inc == MAX_ERR) state_next = ALARM;
                else                         state_next = IDLE;
            end
            OPEN:  if (open_exit) state_next = IDLE;
            ALARM: if (done_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q      <= 1'b0;
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            digit_count <= 3'd0;
            err_count   <= 3'd0;
            entry       <= 24'd0;
            timer       <= 16'd0;
`ifdef CODE_CHANGE_EN
            // NOTE: the code register is reset to CODE so a freshly reset lock
            // always opens with the factory code.
            code_reg     <= CODE;
            code_changed <= 1'b0;
`endif
        end else begin
            done_q <= alarm_done;
            // Outputs decode the next state so they change with the state itself.
            unlock <= (state_next == OPEN);
            alarm  <= (state_next == ALARM);

            case (state)
                CHECK: begin
                    entry       <= 24'd0;
                    digit_count <= 3'd0;
                    if (match) begin
                        err_count <= 3'd0;
                        timer     <= OPEN_LOAD;
                    end else begin
                        err_count <= err_inc;
                    end
                end
                OPEN: begin
                    if (timer != 16'd0) timer <= timer - 16'd1;
                end
                ALARM: begin
                    if (done_rise) err_count <= 3'd0;
                end
                default: ;
            endcase

            if (keys_live) begin
                if (key_clear) begin
                    entry       <= 24'd0;
                    digit_count <= 3'd0;
                end else if (key_enter) begin
                    // In IDLE the entry is frozen for CHECK; in OPEN it is
                    // consumed only by a code change.
                    if (code_load) begin
                        entry       <= 24'd0;
                        digit_count <= 3'd0;
                    end
                end else if (digit_ok) begin
                    entry       <= {entry[19:0], key_digit};
                    digit_count <= digit_count + 3'd1;
                end
            end

`ifdef CODE_CHANGE_EN
            // Partial entries keyed while open must not survive relocking.
            if (open_exit) begin
                entry       <= 24'd0;
                digit_count <= 3'd0;
            end
            code_changed <= code_load;
            if (code_load) code_reg <= entry;
`endif
        end
    end

endmodule

// File: tb/tb_code_entry_checker.sv
// -----------------------------------------------------------------------------
// tb_code_entry_checker
//
// Directed bench for code_entry_checker with default parameters
// (CODE=123456, MAX_TRIES=3, OPEN_CYCLES=5000). Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, so each value seen
// reflects the registers after the most recent edge.
// -----------------------------------------------------------------------------
module tb_code_entry_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        key_enter = 1'b0;
    logic        key_clear = 1'b0;
    logic        key_lock = 1'b0;
    logic        alarm_done = 1'b0;
    logic        unlock;
    logic        alarm;
    logic [2:0]  digit_count;
    logic [2:0]  err_count;
    logic [23:0] entry;
`ifdef CODE_CHANGE_EN
    logic        code_changed;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    code_entry_checker dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .key_enter   (key_enter),
        .key_clear   (key_clear),
        .key_lock    (key_lock),
        .alarm_done  (alarm_done),
        .unlock      (unlock),
        .alarm       (alarm),
        .digit_count (digit_count),
        .err_count   (err_count),
        .entry       (entry)
`ifdef CODE_CHANGE_EN
        ,
        .code_changed(code_changed)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_code(input logic [23:0] code);
        for (int i = 5; i >= 0; i--) press(code[i*4 +: 4]);
    endtask

    // Enter strobe, then the CHECK cycle: returns two edges after the strobe.
    task automatic submit();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_unlock", unlock, 1'b0);
        check("rst_alarm", alarm, 1'b0);
        check("rst_digits", digit_count, 3'd0);
        check("rst_err", err_count, 3'd0);
        check("rst_entry", entry, 24'd0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- 1: correct code opens for 5000 cycles ----------------
        press_code(24'h123456);
        check("t1_entry", entry, 24'h123456);
        check("t1_digits", digit_count, 3'd6);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        check("t1_check_cycle_closed", unlock, 1'b0);
        tick();
        check("t1_unlock", unlock, 1'b1);
        check("t1_entry_cleared", entry, 24'd0);
`ifndef CODE_CHANGE_EN
        press(4'd7);
        check("t1_open_ignores_digit", digit_count, 3'd0);
`else
        tick();
`endif
        n = 1;
        while (unlock && n < 6000) begin
            tick();
            n++;
        end
        check("t1_open_cycles", n, 5000);
        check("t1_err_after", err_count, 3'd0);

        // ---------------- 2: three failures raise the alarm ----------------
        press_code(24'h123457);
        submit();
        check("t2_err1", err_count, 3'd1);
        check("t2_unlock1", unlock, 1'b0);
        press_code(24'h123457);
        submit();
        check("t2_err2", err_count, 3'd2);
        check("t2_alarm_low", alarm, 1'b0);
        press_code(24'h123457);
        submit();
        check("t2_err3", err_count, 3'd3);
        check("t2_alarm", alarm, 1'b1);
        press_code(24'h123456);
        submit();
        check("t2_keys_ignored", digit_count, 3'd0);
        check("t2_alarm_held", alarm, 1'b1);
        check("t2_no_unlock", unlock, 1'b0);
        alarm_done = 1'b1;
        tick();
        alarm_done = 1'b0;
        check("t2_alarm_cleared", alarm, 1'b0);
        check("t2_err_cleared", err_count, 3'd0);

        // ---------------- 3: short entry, overflow, clear priority ----------------
        press(4'd1);
        press(4'd2);
        press(4'd3);
        submit();
        check("t3_short_fail", err_count, 3'd1);
        check("t3_entry_cleared", entry, 24'd0);
        press_code(24'h123456);
        press(4'd9);
        check("t3_seventh_dropped_cnt", digit_count, 3'd6);
        check("t3_seventh_dropped_entry", entry, 24'h123456);
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd5;
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        check("t3_clear_wins", digit_count, 3'd0);
        check("t3_clear_entry", entry, 24'd0);
        press(4'hA);
        press(4'd8);
        check("t3_bad_digit_dropped", entry, 24'h000008);
        check("t3_bad_digit_cnt", digit_count, 3'd1);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;

        // ---------------- 4: alarm_done already high needs a fresh edge ----------------
        alarm_done = 1'b1;
        press_code(24'h111111);
        submit();
        check("t4_err2", err_count, 3'd2);
        press_code(24'h111111);
        submit();
        check("t4_alarm", alarm, 1'b1);
        tick();
        tick();
        check("t4_sticky_no_exit", alarm, 1'b1);
        alarm_done = 1'b0;
        tick();
        check("t4_low_no_exit", alarm, 1'b1);
        alarm_done = 1'b1;
        tick();
        check("t4_edge_exit", alarm, 1'b0);
        check("t4_err_cleared", err_count, 3'd0);
        alarm_done = 1'b0;

        // ---------------- 5: early relock and async reset ----------------
        press_code(24'h123456);
        submit();
        check("t5_unlock", unlock, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        check("t5_still_open", unlock, 1'b1);
        key_lock = 1'b1;
        tick();
        key_lock = 1'b0;
        check("t5_lock", unlock, 1'b0);
        press_code(24'h123456);
        submit();
        check("t5_reopen", unlock, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_async_reset", unlock, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_stays_closed", unlock, 1'b0);

`ifdef CODE_CHANGE_EN
        // ---------------- 6: code change while open ----------------
        press_code(24'h123456);
        submit();
        check("t6_open", unlock, 1'b1);
        press_code(24'h654321);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        check("t6_pulse", code_changed, 1'b1);
        check("t6_still_open", unlock, 1'b1);
        tick();
        check("t6_pulse_end", code_changed, 1'b0);
        key_lock = 1'b1;
        tick();
        key_lock = 1'b0;
        press_code(24'h123456);
        submit();
        check("t6_old_fails", err_count, 3'd1);
        check("t6_old_closed", unlock, 1'b0);
        press_code(24'h654321);
        submit();
        check("t6_new_opens", unlock, 1'b1);
        check("t6_err_cleared", err_count, 3'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_entry_checker.md
Name: code_entry_checker

Overview:
- Upstream stage of the LED flasher in the six-digit electronic lock.
- Collects six BCD key digits and compares them on enter against the stored code.
- Counts consecutive failed attempts and drives `unlock` to the door actuator.
- After MAX_TRIES failures, asserts `alarm`, which drives the flasher's switch input, and holds it until the flasher reports end of flashing.

Parameters:
- CODE, 24'h123456, stored code: six BCD digits; the most significant nibble is the first digit keyed.
- MAX_TRIES, 3, consecutive failures that trigger alarm; legal range 1..7.
- OPEN_CYCLES, 16'd5000, clk cycles `unlock` stays high; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD digit 0..9; values 10..15 are ignored.
- key_enter  in  1  one-cycle strobe: submit the entry.
- key_clear  in  1  one-cycle strobe: discard the entry.
- key_lock  in  1  one-cycle strobe: relock early while OPEN.
- alarm_done  in  1  end-of-flash flag from the flasher, synchronous to clk, may stay high (sticky).
- unlock  out  1  door open.
- alarm  out  1  to flasher switch.
- digit_count  out  3  digits held, 0..6.
- err_count  out  3  consecutive failures.
- entry  out  24  entered digits, right-justified, for display.

Behaviour:
- Reset (async, any state): state=IDLE; unlock=0, alarm=0, digit_count=0, err_count=0, entry=0, alarm_done edge register=0.
- All outputs are registered.
- States: IDLE, CHECK, OPEN, ALARM.
- IDLE:
  - Input priority within one cycle: key_clear > key_enter > key_valid.
  - key_clear: entry=0, digit_count=0.
  - key_enter: next state CHECK; the entry is frozen.
  - key_valid with digit≤9 and digit_count<6: entry={entry[19:0],digit}, digit_count+1.
  - 7th and later digits are dropped; entry is unchanged.
  - Digits >9 are dropped.
- CHECK (exactly 1 cycle):
  - Match: digit_count==6 and entry==CODE. Enter OPEN, err_count=0.
  - Anything else (including a short entry) is a failure: err_count+1.
    - If the new err_count==MAX_TRIES, go to ALARM.
    - Otherwise go to IDLE.
  - On leaving CHECK, entry and digit_count clear to 0.
  - All key inputs are ignored during CHECK.
- Latency: enter strobe at cycle N → CHECK at N+1 → unlock or alarm high at N+2.
- OPEN:
  - unlock=1; an internal counter loads OPEN_CYCLES−1 on entry and decrements.
  - Exit to IDLE when the counter reaches 0 or on key_lock; unlock is 0 from the next cycle.
  - Keys other than key_lock are ignored.
- ALARM:
  - alarm=1; all keys are ignored.
  - Exit on a rising edge of alarm_done, i.e. alarm_done=1 and previous sample=0.
  - On exit: alarm=0 next cycle, err_count=0, state=IDLE.
  - alarm_done already high on entry to ALARM does not exit; a fresh 0→1 transition is required.
- err_count saturates at MAX_TRIES; it never wraps.
- Reset mid-OPEN or mid-ALARM drops unlock/alarm immediately (asynchronously).

Optional Feature:
- Macro: CODE_CHANGE_EN.
- Defined:
  - Code register: 24-bit, reset value CODE, used for all comparisons instead of the constant.
  - key_enter while OPEN with digit_count==6 loads entry into the code register.
    - Clears entry/digit_count.
    - Pulses code_changed (extra 1-bit output) for 1 cycle.
    - Stays in OPEN; the timer is not restarted.
  - Digits are accepted in OPEN with the IDLE rules.
  - key_enter in OPEN with digit_count<6 is ignored.
- Not defined:
  - Comparison uses the CODE parameter.
  - No code_changed port.
  - Digits and key_enter are ignored in OPEN.

Test Plan:
1. Reset, key 1,2,3,4,5,6, enter → CHECK 1 cycle, unlock=1 two cycles after enter, for 5000 cycles, then IDLE with err_count=0.
2. Key 1,2,3,4,5,7, enter, three times (MAX_TRIES=3) → err_count 1, 2, then alarm=1. Keys are ignored while alarm=1. Pulse alarm_done 0→1 → alarm=0, err_count=0.
3. Key 1,2,3, enter → failure (err_count=1). Key 1..6 plus 9 → digit_count=6, entry=24'h123456. Then key_clear together with key_valid in the same cycle → digit_count=0.
4. alarm_done held high before the third failure → alarm stays 1 until alarm_done goes 0 then 1.
5. Correct code, then key_lock 10 cycles into OPEN → unlock=0 next cycle. Assert rst while unlock=1 → unlock=0 asynchronously.
6. With CODE_CHANGE_EN defined: open, key 6,5,4,3,2,1, enter → code_changed pulse. Relock; 123456 fails; 654321 opens.
